// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one single-port byte-write BRAM between a CPU path (r0) and a FIR path (r1).
// Optional grant statistics are built when BRAM_ARB_STATS_EN is defined.
module bram_arbiter #(
    parameter int DELAYS = 10,
    parameter int CNT_W  = 16
) (
    input  logic             axis_clk,
    input  logic             axis_rst_n,
    input  logic             r0_req,
    input  logic [3:0]       r0_we,
    input  logic [31:0]      r0_addr,
    input  logic [31:0]      r0_wdata,
    output logic             r0_ack,
    output logic [31:0]      r0_rdata,
    input  logic             r1_req,
    input  logic [3:0]       r1_we,
    input  logic [31:0]      r1_addr,
    input  logic [31:0]      r1_wdata,
    output logic             r1_ack,
    output logic [31:0]      r1_rdata,
    output logic             bram_en,
    output logic [3:0]       bram_we,
    output logic [31:0]      bram_a,
    output logic [31:0]      bram_di,
    input  logic [31:0]      bram_do,
    output logic             busy,
    output logic [CNT_W-1:0] r0_grant_cnt,
    output logic [CNT_W-1:0] r1_grant_cnt
);

    typedef enum logic [2:0] {IDLE, ISSUE, CAPT, WAIT, ACK} state_t;

    // The counter is preloaded with DELAYS-1 so that WAIT lasts exactly DELAYS cycles.
    localparam int WCNT_W = (DELAYS > 1) ? $clog2(DELAYS) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LOAD = (DELAYS > 0) ? WCNT_W'(DELAYS - 1) : '0;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wait_q, wait_d;
    logic              last_q, last_d;
    logic              id_q, id_d;
    logic [3:0]        we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       di_q, di_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              winner;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{r0_addr[1:0], r1_addr[1:0]};

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q <= IDLE;
            wait_q  <= '0;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            we_q    <= '0;
            addr_q  <= '0;
            di_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            last_q  <= last_d;
            id_q    <= id_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            di_q    <= di_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        last_d  = last_q;
        id_d    = id_q;
        we_d    = we_q;
        addr_d  = addr_q;
        di_d    = di_q;
        rdata_d = rdata_q;
        winner  = 1'b0;
        case (state_q)
            IDLE: begin
                if (r0_req || r1_req) begin
                    // On a tie the requester that did not win last time goes first.
                    winner  = (r0_req && r1_req) ? ~last_q : r1_req;
                    id_d    = winner;
                    last_d  = winner;
                    we_d    = winner ? r1_we : r0_we;
                    addr_d  = winner ? {2'b00, r1_addr[31:2]} : {2'b00, r0_addr[31:2]};
                    di_d    = winner ? r1_wdata : r0_wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = CAPT;
            CAPT: begin
                rdata_d = bram_do;
                if (DELAYS == 0) begin
                    state_d = ACK;
                end else begin
                    wait_d  = WAIT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (wait_q == '0) begin
                    state_d = ACK;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bram_en  = (state_q == ISSUE);
    assign bram_we  = (state_q == ISSUE) ? we_q : 4'h0;
    assign bram_a   = addr_q;
    assign bram_di  = di_q;
    assign busy     = (state_q != IDLE);
    assign r0_ack   = (state_q == ACK) && !id_q;
    assign r1_ack   = (state_q == ACK) && id_q;
    assign r0_rdata = r0_ack ? rdata_q : 32'h0;
    assign r1_rdata = r1_ack ? rdata_q : 32'h0;

`ifdef BRAM_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;
    logic             grant;

    assign grant  = (state_q == IDLE) && (state_d == ISSUE);
    assign cnt0_d = (grant && !last_d) ? cnt0_q + CNT_W'(1) : cnt0_q;
    assign cnt1_d = (grant && last_d)  ? cnt1_q + CNT_W'(1) : cnt1_q;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign r0_grant_cnt = cnt0_q;
    assign r1_grant_cnt = cnt1_q;
`else
    assign r0_grant_cnt = '0;
    assign r1_grant_cnt = '0;
`endif

endmodule
